// File: rtl/ckpt_regfile_pkg.sv
// Shared types for the checkpointed speculative register file: data/tag/index
// types, the NO_VAL tag and the recovery FSM states.
package ckpt_regfile_pkg;

  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;
  localparam int TAG_W      = 4;
  localparam int NUM_CKPT   = 4;
  localparam int REG_IDX_W  = $clog2(NUM_REGS);
  localparam int CKPT_ID_W  = $clog2(NUM_CKPT);

  typedef logic [XLEN-1:0]      word32_t;
  typedef logic [TAG_W-1:0]     rs_tag_t;
  typedef logic [REG_IDX_W-1:0] regfile_idx_t;
  typedef logic [CKPT_ID_W-1:0] ckpt_id_t;

  localparam rs_tag_t NO_VAL = '0;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } rf_state_e;

endpackage

// File: rtl/ckpt_regfile_if.sv
// Issue/CDB/branch-unit side of the checkpointed register file, bundled into
// one interface; the file itself is the slave.
interface ckpt_regfile_if #(
  parameter int NUM_RD   = 2,
  parameter int NUM_CDB  = 2,
  parameter int NUM_CKPT = 4
);
  import ckpt_regfile_pkg::*;

  logic [NUM_CDB-1:0]          cdb_valid;
  rs_tag_t                     cdb_tag [NUM_CDB];
  word32_t                     cdb_val [NUM_CDB];

  regfile_idx_t                rd_idx  [NUM_RD];
  word32_t                     rd_data [NUM_RD];
  rs_tag_t                     rd_tag  [NUM_RD];

  logic                        tag_wr_en;
  regfile_idx_t                tag_wr_idx;
  rs_tag_t                     tag_wr_tag;

  logic                        ckpt_take;
  logic [$clog2(NUM_CKPT)-1:0] ckpt_id;
  logic                        ckpt_full;

  logic                        resolve;
  logic                        resolve_correct;
  logic                        busy;
  logic                        err;

  modport master (
    output cdb_valid, cdb_tag, cdb_val, rd_idx, tag_wr_en, tag_wr_idx,
           tag_wr_tag, ckpt_take, resolve, resolve_correct,
    input  rd_data, rd_tag, ckpt_id, ckpt_full, busy, err
  );

  modport slave (
    input  cdb_valid, cdb_tag, cdb_val, rd_idx, tag_wr_en, tag_wr_idx,
           tag_wr_tag, ckpt_take, resolve, resolve_correct,
    output rd_data, rd_tag, ckpt_id, ckpt_full, busy, err
  );

endinterface

// File: rtl/ckpt_regfile_slot.sv
// One snapshot of register values and producer tags. A load replaces the
// contents; CDB hits and an optional tag write are then layered on top.
module ckpt_regfile_slot
  import ckpt_regfile_pkg::*;
#(
  parameter int NUM_CDB = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  word32_t            load_vals [NUM_REGS],
  input  rs_tag_t            load_tags [NUM_REGS],
  input  logic [NUM_CDB-1:0] cdb_valid,
  input  rs_tag_t            cdb_tag   [NUM_CDB],
  input  word32_t            cdb_val   [NUM_CDB],
  input  logic               wr_en,
  input  regfile_idx_t       wr_idx,
  input  rs_tag_t            wr_tag,
  output word32_t            vals      [NUM_REGS],
  output rs_tag_t            tags      [NUM_REGS]
);

  word32_t nxt_vals [NUM_REGS];
  rs_tag_t nxt_tags [NUM_REGS];

  // Buses are scanned high to low so the lowest-index matching bus wins.
  always_comb begin
    word32_t base_val;
    rs_tag_t base_tag;
    base_val = '0;
    base_tag = NO_VAL;
    for (int r = 0; r < NUM_REGS; r++) begin
      base_val    = load ? load_vals[r] : vals[r];
      base_tag    = load ? load_tags[r] : tags[r];
      nxt_vals[r] = base_val;
      nxt_tags[r] = base_tag;
      for (int b = NUM_CDB - 1; b >= 0; b--) begin
        if (cdb_valid[b] && cdb_tag[b] != NO_VAL && cdb_tag[b] == base_tag) begin
          nxt_vals[r] = cdb_val[b];
          nxt_tags[r] = NO_VAL;
        end
      end
    end
    if (wr_en && wr_idx != '0 && wr_tag != NO_VAL)
      nxt_tags[wr_idx] = wr_tag;
    nxt_vals[0] = '0;
    nxt_tags[0] = NO_VAL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        vals[r] <= '0;
        tags[r] <= NO_VAL;
      end
    end else begin
      vals <= nxt_vals;
      tags <= nxt_tags;
    end
  end

endmodule

// File: rtl/ckpt_regfile.sv
// Speculative register file with up to NUM_CKPT nested branch checkpoints,
// resolved oldest-first, and a one-cycle recovery state after a mispredict.
module ckpt_regfile
  import ckpt_regfile_pkg::*;
#(
  parameter int NUM_RD   = 2,
  parameter int NUM_CDB  = 2,
  parameter int NUM_CKPT = 4
) (
  input logic           clk,
  input logic           rst_n,
  ckpt_regfile_if.slave bus
);

  localparam int CW = $clog2(NUM_CKPT);
  localparam logic [CW:0] FULL_CNT = (CW + 1)'(NUM_CKPT);

  rf_state_e   state, state_nxt;
  logic [CW-1:0] head, tail, head_nxt, tail_nxt;
  logic [CW:0]   count, count_nxt;
  logic          full_q, err_q;

  logic in_rec, take_req, res_req, empty, full_now;
  logic pop, mispredict, take_ok, live_wr, dup, err_evt;

  rs_tag_t cdb_tag [NUM_CDB];
  word32_t cdb_val [NUM_CDB];
  word32_t live_vals [NUM_REGS];
  rs_tag_t live_tags [NUM_REGS];
  word32_t head_vals [NUM_REGS];
  rs_tag_t head_tags [NUM_REGS];
  word32_t ck_vals   [NUM_CKPT][NUM_REGS];
  rs_tag_t ck_tags   [NUM_CKPT][NUM_REGS];
  word32_t rd_data   [NUM_RD];
  rs_tag_t rd_tag    [NUM_RD];

  for (genvar b = 0; b < NUM_CDB; b++) begin : g_cdb
    assign cdb_tag[b] = bus.cdb_tag[b];
    assign cdb_val[b] = bus.cdb_val[b];
  end

  always_comb begin
    dup = 1'b0;
    for (int a = 0; a < NUM_CDB; a++)
      for (int b = a + 1; b < NUM_CDB; b++)
        if (bus.cdb_valid[a] && bus.cdb_valid[b] && cdb_tag[a] != NO_VAL &&
            cdb_tag[a] == cdb_tag[b])
          dup = 1'b1;
  end

  // Resolve is evaluated before take so that a mispredict drops a same-cycle
  // take, while a correct pop frees room for a take even when full.
  always_comb begin
    in_rec     = (state == RECOVER);
    take_req   = bus.ckpt_take && !in_rec;
    res_req    = bus.resolve && !in_rec;
    empty      = (count == '0);
    full_now   = (count == FULL_CNT);
    pop        = res_req && !empty && bus.resolve_correct;
    mispredict = res_req && !empty && !bus.resolve_correct;
    take_ok    = take_req && !mispredict && (!full_now || pop);
    live_wr    = bus.tag_wr_en && !in_rec && !mispredict;
    err_evt    = dup
              || (in_rec && (bus.tag_wr_en || bus.ckpt_take || bus.resolve))
              || (res_req && empty)
              || (take_req && !mispredict && full_now && !pop);
    if (mispredict) begin
      head_nxt  = head;
      tail_nxt  = head;
      count_nxt = '0;
    end else begin
      head_nxt  = head + CW'(pop);
      tail_nxt  = tail + CW'(take_ok);
      count_nxt = count + (CW + 1)'(take_ok) - (CW + 1)'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      full_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      head   <= head_nxt;
      tail   <= tail_nxt;
      count  <= count_nxt;
      full_q <= (count_nxt == FULL_CNT);
      err_q  <= err_q | err_evt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = RUN;
    case (state)
      RUN:     state_nxt = mispredict ? RECOVER : RUN;
      RECOVER: state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    bus.busy      = (state == RECOVER);
    bus.ckpt_full = full_q;
    bus.err       = err_q;
    bus.ckpt_id   = tail;
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      head_vals[r] = ck_vals[head][r];
      head_tags[r] = ck_tags[head][r];
    end
  end

  ckpt_regfile_slot #(.NUM_CDB(NUM_CDB)) u_live (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (mispredict),
    .load_vals (head_vals),
    .load_tags (head_tags),
    .cdb_valid (bus.cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_val   (cdb_val),
    .wr_en     (live_wr),
    .wr_idx    (bus.tag_wr_idx),
    .wr_tag    (bus.tag_wr_tag),
    .vals      (live_vals),
    .tags      (live_tags)
  );

  // A taking slot loads the pre-update live file and replays the same CDB
  // hits and rename, which lands exactly on the live file's next state.
  for (genvar i = 0; i < NUM_CKPT; i++) begin : g_ckpt
    logic take_here;
    assign take_here = take_ok && (tail == CW'(i));

    ckpt_regfile_slot #(.NUM_CDB(NUM_CDB)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (take_here),
      .load_vals (live_vals),
      .load_tags (live_tags),
      .cdb_valid (bus.cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_val   (cdb_val),
      .wr_en     (live_wr && take_here),
      .wr_idx    (bus.tag_wr_idx),
      .wr_tag    (bus.tag_wr_tag),
      .vals      (ck_vals[i]),
      .tags      (ck_tags[i])
    );
  end

  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_data[p] = live_vals[bus.rd_idx[p]];
      rd_tag[p]  = live_tags[bus.rd_idx[p]];
      if (bus.tag_wr_en && !in_rec && bus.tag_wr_idx == bus.rd_idx[p] &&
          bus.tag_wr_tag != NO_VAL)
        rd_tag[p] = bus.tag_wr_tag;
      if (bus.rd_idx[p] == '0) begin
        rd_data[p] = '0;
        rd_tag[p]  = NO_VAL;
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    assign bus.rd_data[p] = rd_data[p];
    assign bus.rd_tag[p]  = rd_tag[p];
  end

endmodule

// File: doc/ckpt_regfile.md
Name: ckpt_regfile

Overview:
- Parametrised successor to the single-snapshot speculative register file.
- Holds architectural values plus per-register producer tags (register status).
- Keeps up to NUM_CKPT nested branch checkpoints, resolved oldest-first.
- Sits between issue logic, the reservation stations, NUM_CDB common data buses, and the branch unit.

Parameters:
XLEN, 32, data width
NUM_REGS, 32, register count (r0 hardwired to 0)
TAG_W, 4, RS tag width; tag value 0 is NO_VAL
NUM_RD, 2, read ports (each returns value and tag)
NUM_CDB, 2, CDB write ports
NUM_CKPT, 4, maximum outstanding checkpoints (power of 2, at least 2)

Ports:
clk_i  in  1  system clock
reset_ni  in  1  asynchronous active-low reset
cdb_valid_i  in  NUM_CDB  per-bus valid
cdb_tag_i  in  NUM_CDB x TAG_W  broadcast tags
cdb_val_i  in  NUM_CDB x XLEN  broadcast values
rd_idx_i  in  NUM_RD x log2(NUM_REGS)  read indices
rd_data_o  out  NUM_RD x XLEN  read values
rd_tag_o  out  NUM_RD x TAG_W  read tags
tag_wr_en_i  in  1  rename write enable
tag_wr_idx_i  in  log2(NUM_REGS)  destination register
tag_wr_tag_i  in  TAG_W  new producer tag
ckpt_take_i  in  1  take a checkpoint (branch issued)
ckpt_id_o  out  log2(NUM_CKPT)  id assigned to ckpt_take_i this cycle
ckpt_full_o  out  1  NUM_CKPT checkpoints outstanding
resolve_i  in  1  oldest branch resolved
resolve_correct_i  in  1  1 = prediction correct
busy_o  out  1  recovery in progress; issue must stall
err_o  out  1  sticky protocol error

Behaviour:
- Reset (asynchronous, reset_ni=0):
  - All values 0, all tags NO_VAL, checkpoint queue empty, FSM in RUN.
  - busy_o=0, ckpt_full_o=0, err_o=0, ckpt_id_o=0.
- Reads are combinational.
  - rd_tag_o bypasses a same-cycle tag write to the same index when that write is non-zero and not NO_VAL.
  - rd_data_o has no bypass.
  - Index 0 always returns value 0 and tag NO_VAL.
- CDB update, each cycle, on the live file and on every valid checkpoint:
  - For each register whose tag equals a valid, non-NO_VAL cdb_tag, write that bus's value and set its tag to NO_VAL.
  - Two buses carrying the same tag in one cycle sets err_o; the lower-index bus wins.
- Tag write:
  - Applies to the live file only; ignored for index 0 and for NO_VAL.
  - When it coincides with a CDB hit on the same register: value is taken from the CDB, tag is set to tag_wr_tag_i.
- Checkpoint queue: circular buffer with head (oldest) and tail pointers and a count.
  - ckpt_take_i copies the post-update live state into slot tail, i.e. including same-cycle CDB writes and the same-cycle tag write.
  - ckpt_id_o = tail.
  - Take while full: ignored, err_o set.
- Resolve:
  - resolve_i with an empty queue: ignored, err_o set.
  - Correct: pop head.
  - Incorrect: live file is overwritten from slot head, with same-cycle CDB hits merged; the queue is flushed (count=0, tail=head); FSM goes to RECOVER.
- Same-cycle take and correct resolve: both happen, count unchanged; legal even when full.
- Same-cycle take and mispredict: mispredict wins, the take is dropped.
- FSM:
  - RUN: mispredict -> RECOVER.
  - RECOVER, exactly 1 cycle: busy_o=1; tag writes, takes and resolves are ignored (err_o set if asserted); CDB updates continue; -> RUN.
- Pointers wrap modulo NUM_CKPT.
- ckpt_full_o = (count == NUM_CKPT), registered.
- Reset asserted mid-recovery returns everything to the reset state.

Decomposition:
- Shared package: rs_tag_t, NO_VAL, word32_t, regfile_idx_t, and a new ckpt_id_t.
- Natural sub-module: ckpt_regfile_slot. One snapshot of values and tags, with load and a CDB-update port; instantiated NUM_CKPT times and also reused as the live file.

Test Plan:
- Reset, then read r5 -> value 0, tag NO_VAL; r0 after a tag write of 3 -> still tag NO_VAL.
- Tag write r5<-3, then CDB {tag 3, val 0xDEAD} -> r5=0xDEAD, tag NO_VAL; same-cycle read of r5 tag returns 3.
- Take ckpt (id 0), tag write r7<-4, CDB {tag 4, 0x11}, mispredict -> busy_o=1 for 1 cycle; r7 restored to its pre-branch value/tag with ckpt CDB merges; queue empty.
- Four takes -> ckpt_full_o=1; fifth take -> ignored, err_o=1; take plus correct resolve in the same cycle -> count stays 4, ids wrap 0..3,0.
- Nested: take A, take B, resolve correct (pops A), resolve wrong -> state restored to B's snapshot.
- Drop reset_ni during RECOVER -> all outputs at reset values asynchronously.
